// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receive deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_t;

  // I2S places the MSB one BCLK after the LRCLK transition
  localparam int I2S_BIT_DELAY = 1;

  localparam int DEFAULT_SLOT_BITS = 32;

  // Bit counter must hold 0 .. SLOT_BITS+1 (saturation value marks overrun)
  function automatic int cnt_width(input int slot_bits);
    return $clog2(slot_bits + 2);
  endfunction

  localparam int CNT_W = $clog2(DEFAULT_SLOT_BITS + 2);

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronizes a strobe line plus companion data bits and flags strobe rises.
// Latency: SYNC_STAGES+1 clk from input change to dout/rise.
// Backpressure: none; free-running, outputs valid every cycle.
module i2s_sync_edge #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rise
);

  // Strobe rides in bit 0 so data and strobe see identical delay
  logic [WIDTH:0] sync_q [SYNC_STAGES];
  logic           strobe_prev;

  // Synchronizer chain for strobe and data together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {din, strobe_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Registered rise detect, data registered alongside to stay aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout        <= '0;
      strobe_prev <= 1'b0;
      rise        <= 1'b0;
    end else begin
      dout        <= sync_q[SYNC_STAGES-1][WIDTH:1];
      strobe_prev <= sync_q[SYNC_STAGES-1][0];
      rise        <= sync_q[SYNC_STAGES-1][0] & ~strobe_prev;
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S ADC receiver: deserializes MSB-first left/right words into a stereo pair.
// Latency: sample_valid SYNC_STAGES+2 clk after the last right bit's BCLK high is registered.
// Backpressure: none; sample_valid is a one-cycle strobe, outputs hold between strobes.
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_l,
  output logic [SAMPLE_WIDTH-1:0] sample_r,
  output logic                    sample_valid,
  output logic                    frame_error,
  output logic                    locked
);

  localparam int CW = cnt_width(SLOT_BITS);
  localparam logic [CW-1:0] CNT_FIRST = CW'(I2S_BIT_DELAY);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_WIDTH + I2S_BIT_DELAY - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(SLOT_BITS + 1);

  logic [1:0]              sync_dat;
  logic                    bit_vld;
  logic                    lr_dat;
  logic                    sd_dat;
  rx_state_t               state;
  rx_state_t               state_nxt;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_inc;
  logic                    lr_prev;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [SAMPLE_WIDTH-1:0] shift_nxt;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    slot_edge;
  logic                    short_slot;
  logic                    overrun;
  logic                    data_bit;
  logic                    word_done;
  logic                    err_evt;
  logic                    latch_left;
  logic                    pair_done;
  logic                    done_q;

  i2s_sync_edge #(
    .WIDTH       (2),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .strobe_in (i2s_bclk),
    .din       ({i2s_sdata, i2s_lrclk}),
    .dout      (sync_dat),
    .rise      (bit_vld)
  );

  assign lr_dat = sync_dat[0];
  assign sd_dat = sync_dat[1];

  // Per-BCLK-rise events: slot boundary, short slot, lost LRCLK, data and word completion
  always_comb begin
    slot_edge  = bit_vld && (lr_dat != lr_prev);
    cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    short_slot = slot_edge && (cnt < CNT_LAST);
    overrun    = bit_vld && !slot_edge && (cnt_inc == CNT_SAT);
    data_bit   = bit_vld && !slot_edge && (cnt_inc >= CNT_FIRST) && (cnt_inc <= CNT_LAST);
    word_done  = data_bit && (cnt_inc == CNT_LAST);
    shift_nxt  = {shift_q[SAMPLE_WIDTH-2:0], sd_dat};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC_WAIT;
    else          state <= state_nxt;
  end

  // FSM next state: lock on a right-to-left boundary, drop lock on any malformed slot
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC_WAIT: if (slot_edge && !lr_dat) state_nxt = LEFT;
      LEFT: begin
        if (short_slot || overrun) state_nxt = SYNC_WAIT;
        else if (slot_edge)        state_nxt = RIGHT;
      end
      RIGHT: begin
        if (short_slot || overrun) state_nxt = SYNC_WAIT;
        else if (slot_edge)        state_nxt = LEFT;
      end
      default: state_nxt = SYNC_WAIT;
    endcase
  end

  // FSM outputs: lock status and the per-word control strobes
  always_comb begin
    locked     = (state != SYNC_WAIT);
    err_evt    = (state != SYNC_WAIT) && (short_slot || overrun);
    latch_left = (state == LEFT) && word_done;
    pair_done  = (state == RIGHT) && word_done;
  end

  // Bit counter, channel tracking and word shift register, advanced on BCLK rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      lr_prev   <= 1'b0;
      shift_q   <= '0;
      left_hold <= '0;
    end else if (bit_vld) begin
      lr_prev <= lr_dat;
      if (slot_edge) begin
        cnt     <= '0;
        shift_q <= '0;
      end else begin
        cnt <= cnt_inc;
        if (data_bit) shift_q <= shift_nxt;
      end
      if (latch_left) left_hold <= shift_nxt;
    end
  end

  // Publish the pair one cycle after the right word completes; error strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q       <= 1'b0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
    end else begin
      done_q       <= pair_done;
      sample_valid <= done_q;
      frame_error  <= err_evt;
      if (done_q) begin
        sample_l <= left_hold;
        sample_r <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for the I2S receive deserializer.
// Latency: checks strobe timing against the last right bit's BCLK rise.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;

  localparam int SAMPLE_WIDTH = 24;
  localparam int SLOT_BITS    = 32;
  localparam int SYNC_STAGES  = 2;
  localparam int HALF_BCLK    = 16;
  localparam int BCLK_CYC     = 2 * HALF_BCLK;

  logic                    clk       = 1'b0;
  logic                    reset_n   = 1'b0;
  logic                    i2s_bclk  = 1'b0;
  logic                    i2s_lrclk = 1'b0;
  logic                    i2s_sdata = 1'b0;
  logic [SAMPLE_WIDTH-1:0] sample_l;
  logic [SAMPLE_WIDTH-1:0] sample_r;
  logic                    sample_valid;
  logic                    frame_error;
  logic                    locked;

  i2s_rx_deserializer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SLOT_BITS    (SLOT_BITS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .frame_error  (frame_error),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor
  int                      n_valid    = 0;
  int                      n_err      = 0;
  int                      n_consec   = 0;
  logic                    prev_valid = 1'b0;
  logic [SAMPLE_WIDTH-1:0] q_l [$];
  logic [SAMPLE_WIDTH-1:0] q_r [$];
  longint                  q_cyc [$];
  longint                  rb_cyc [$];

  always @(negedge clk) begin
    if (sample_valid) begin
      q_l.push_back(sample_l);
      q_r.push_back(sample_r);
      q_cyc.push_back(cyc);
      n_valid++;
      if (prev_valid) n_consec++;
    end
    if (frame_error) n_err++;
    prev_valid = sample_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One BCLK period starting at a clk negedge; mark records the edge that first registers BCLK high
  task automatic send_bit(input logic lr, input logic d, input logic mark);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = d;
    repeat (HALF_BCLK) @(negedge clk);
    i2s_bclk = 1'b1;
    if (mark) rb_cyc.push_back(cyc + 1);
    repeat (HALF_BCLK) @(negedge clk);
  endtask

  // Slot: delay bit, MSB-first word, trailing pad; delay and pad bits are 1 so stray shifts show up
  task automatic send_slot(input logic lr, input logic [SAMPLE_WIDTH-1:0] word, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      logic d;
      d = (k >= 1 && k <= SAMPLE_WIDTH) ? word[SAMPLE_WIDTH-k] : 1'b1;
      send_bit(lr, d, lr && (k == SAMPLE_WIDTH));
    end
  endtask

  task automatic send_frame(input logic [SAMPLE_WIDTH-1:0] l, input logic [SAMPLE_WIDTH-1:0] r);
    send_slot(1'b0, l, SLOT_BITS);
    send_slot(1'b1, r, SLOT_BITS);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int v0;
    int e0;
    int s0;
    int r0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_l",      {8'h0, sample_l}, 32'h0);
    check_eq("rst_r",      {8'h0, sample_r}, 32'h0);
    check_eq("rst_valid",  {31'h0, sample_valid}, 32'h0);
    check_eq("rst_err",    {31'h0, frame_error}, 32'h0);
    check_eq("rst_locked", {31'h0, locked}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal frame
    v0 = n_valid; e0 = n_err;
    send_slot(1'b1, 24'h5A5A5A, SLOT_BITS);
    send_frame(24'hA55AC3, 24'h123456);
    check_eq("t1_strobes", n_valid - v0, 1);
    check_eq("t1_l", {8'h0, sample_l}, 32'hA55AC3);
    check_eq("t1_r", {8'h0, sample_r}, 32'h123456);
    check_eq("t1_err", n_err - e0, 0);
    check_eq("t1_locked", {31'h0, locked}, 32'h1);
    check_eq("t1_latency", 32'(q_cyc[$] - rb_cyc[$]), SYNC_STAGES + 2);

    // Start mid right slot after reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    v0 = n_valid;
    send_slot(1'b1, 24'hC0FFEE, 12);
    check_eq("t2_partial_strobes", n_valid - v0, 0);
    check_eq("t2_partial_locked", {31'h0, locked}, 32'h0);
    send_frame(24'h000001, 24'hFFFFFF);
    check_eq("t2_strobes", n_valid - v0, 1);
    check_eq("t2_l", {8'h0, sample_l}, 32'h000001);
    check_eq("t2_r", {8'h0, sample_r}, 32'hFFFFFF);
    check_eq("t2_locked", {31'h0, locked}, 32'h1);

    // Short right slot (10 bits)
    v0 = n_valid; e0 = n_err;
    send_slot(1'b0, 24'h0F0F0F, SLOT_BITS);
    send_slot(1'b1, 24'hFFFFFF, 10);
    send_slot(1'b0, 24'h111111, SLOT_BITS);
    check_eq("t3_err", n_err - e0, 1);
    check_eq("t3_locked", {31'h0, locked}, 32'h0);
    check_eq("t3_strobes_err", n_valid - v0, 0);
    send_slot(1'b1, 24'h222222, SLOT_BITS);
    check_eq("t3_strobes_frame1", n_valid - v0, 0);
    send_frame(24'h333333, 24'h444444);
    check_eq("t3_strobes_frame2", n_valid - v0, 1);
    check_eq("t3_l", {8'h0, sample_l}, 32'h333333);
    check_eq("t3_r", {8'h0, sample_r}, 32'h444444);
    check_eq("t3_err_once", n_err - e0, 1);

    // Stuck LRCLK: 33 bits legal, 34th overruns
    v0 = n_valid; e0 = n_err;
    send_slot(1'b0, 24'h555555, SLOT_BITS + 1);
    check_eq("t4_err_at_limit", n_err - e0, 0);
    check_eq("t4_locked_at_limit", {31'h0, locked}, 32'h1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1, 1'b0);
    check_eq("t4_err", n_err - e0, 1);
    check_eq("t4_locked", {31'h0, locked}, 32'h0);
    check_eq("t4_strobes", n_valid - v0, 0);

    // Reset mid left word
    send_slot(1'b1, 24'h666666, SLOT_BITS);
    send_slot(1'b0, 24'h777777, 12);
    check_eq("t5_locked_pre", {31'h0, locked}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_l", {8'h0, sample_l}, 32'h0);
    check_eq("t5_rst_r", {8'h0, sample_r}, 32'h0);
    check_eq("t5_rst_locked", {31'h0, locked}, 32'h0);
    check_eq("t5_rst_err", {31'h0, frame_error}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    v0 = n_valid;
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 24'h999999, SLOT_BITS);
    check_eq("t5_strobes_pre", n_valid - v0, 0);
    send_frame(24'h800000, 24'h7FFFFF);
    check_eq("t5_strobes", n_valid - v0, 1);
    check_eq("t5_l", {8'h0, sample_l}, 32'h800000);
    check_eq("t5_r", {8'h0, sample_r}, 32'h7FFFFF);

    // Back-to-back frames
    v0 = n_valid;
    s0 = q_cyc.size();
    r0 = rb_cyc.size();
    for (int i = 0; i < 4; i++) send_frame(24'(32'h100000 + i), 24'(32'h200000 + i));
    check_eq("t6_strobes", n_valid - v0, 4);
    for (int i = 0; i < 4; i++) begin
      if (q_cyc.size() > s0 + i && rb_cyc.size() > r0 + i) begin
        check_eq($sformatf("t6_l%0d", i), {8'h0, q_l[s0+i]}, 32'h100000 + i);
        check_eq($sformatf("t6_r%0d", i), {8'h0, q_r[s0+i]}, 32'h200000 + i);
        check_eq($sformatf("t6_lat%0d", i), 32'(q_cyc[s0+i] - rb_cyc[r0+i]), SYNC_STAGES + 2);
        if (i > 0)
          check_eq($sformatf("t6_gap%0d", i), 32'(q_cyc[s0+i] - q_cyc[s0+i-1]), 2 * SLOT_BITS * BCLK_CYC);
      end
    end

    check_eq("no_consec_valid", n_consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
- Receive-side counterpart to the codec playback path: captures ADC (line-in) audio from the ADAU1761 I2S serial data line.
- Oversamples i2s_bclk, i2s_lrclk and i2s_sdata in the clk domain and deserializes MSB-first left/right words.
- Publishes each complete stereo pair with a one-cycle sample_valid strobe, so line_in_l/line_in_r and the waveform display can be driven from real input instead of constants.

Parameters:
- SAMPLE_WIDTH, 24, bits captured per channel word (MSB-first).
- SLOT_BITS, 32, nominal BCLK periods per LRCLK half-frame; the maximum legal slot length.
- SYNC_STAGES, 2, synchronizer flop depth on each I2S input (≥2).

Ports:
- clk, input, 1, system clock (100 MHz); single clock domain.
- reset_n, input, 1, reset; asynchronous assert, active-low.
- i2s_bclk, input, 1, codec bit clock, treated as data.
- i2s_lrclk, input, 1, word select: 0 = left, 1 = right.
- i2s_sdata, input, 1, serial ADC data from the codec.
- sample_l, output, SAMPLE_WIDTH, last complete left word.
- sample_r, output, SAMPLE_WIDTH, last complete right word.
- sample_valid, output, 1, one-cycle strobe when sample_l/sample_r update together.
- frame_error, output, 1, one-cycle strobe on a malformed slot.
- locked, output, 1, high while aligned to the frame structure.

Behaviour:
- Reset (async, reset_n = 0):
  - sample_l, sample_r = 0; sample_valid, frame_error, locked = 0.
  - All synchronizers, counters and shift registers cleared; state = SYNC_WAIT.
  - Reset mid-word discards the partial word. No output strobe may occur until a full new left+right frame has been received.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops.
  - A BCLK rise is detected when the synced bclk is 1 and was 0 the previous clk cycle.
  - lrclk and sdata are sampled only on that rise cycle. Synced lrclk/sdata share bclk's delay so skew stays aligned.
- Input timing requirement: BCLK high and low phases each ≥3 clk cycles. 3.072 MHz BCLK at 100 MHz clk satisfies this.
- Bit counter (cnt), on each BCLK rise:
  - If sampled lrclk ≠ previous sampled lrclk (slot boundary): cnt = 0, channel = new lrclk. The bit sampled on this edge is the I2S one-bit delay position and is ignored.
  - Otherwise cnt increments, saturating at SLOT_BITS+1.
  - For 1 ≤ cnt ≤ SAMPLE_WIDTH, shift sdata into the channel shift register LSB-side (MSB arrives first).
  - Bits after SAMPLE_WIDTH are ignored.
- FSM states: SYNC_WAIT, LEFT, RIGHT.
  - SYNC_WAIT: ignore data until an lrclk 1→0 boundary, then go to LEFT and set locked = 1.
  - LEFT: when cnt reaches SAMPLE_WIDTH, latch the word into left_hold. On a 0→1 boundary go to RIGHT.
  - RIGHT: when cnt reaches SAMPLE_WIDTH, the pair is complete. On a 1→0 boundary go to LEFT.
- Pair completion: on the cycle after the right word completes, load sample_l ← left_hold and sample_r ← right word together, and pulse sample_valid for exactly 1 cycle.
- Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the clk edge at which the right word's final bit's BCLK high is first registered.
- Error cases, each of which pulses frame_error for 1 cycle, sets locked = 0, returns to SYNC_WAIT, and never pulses sample_valid:
  - Slot boundary arrives with cnt < SAMPLE_WIDTH (short slot): partial word discarded.
  - cnt exceeds SLOT_BITS without a boundary (lost LRCLK).
- Left word without a following right word: never published; left_hold is overwritten by the next left word.
- Hold behaviour: sample_l/sample_r hold their values between strobes. sample_valid is never asserted in consecutive cycles.

Decomposition:
- Package i2s_rx_pkg holds:
  - FSM state enum (SYNC_WAIT, LEFT, RIGHT);
  - counter width localparam, clog2(SLOT_BITS+2);
  - the I2S one-bit-delay constant (1).
- Sub-module i2s_sync_edge: one instance per input bundle. It provides the SYNC_STAGES synchronizer plus a registered rising-edge detect, outputting the synced value and rise pulse.

Test Plan:
- Nominal frame: left = 24'hA5_5A_C3, right = 24'h12_34_56, SLOT_BITS = 32, BCLK = 32 clk cycles. Required: one sample_valid pulse, sample_l = A55AC3, sample_r = 123456, frame_error = 0, locked = 1.
- Start mid-right-slot after reset: the first partial frame produces no strobe. The next full frame (L = 24'h000001, R = 24'hFFFFFF) produces exactly one strobe with those values.
- Short slot: LRCLK toggles after 10 right-channel bits. Required: frame_error pulses once, locked = 0, no sample_valid. The following two clean frames yield exactly one strobe, on the second frame.
- Stuck LRCLK: held low for 40 BCLKs. Required: frame_error when cnt passes 32, locked = 0.
- Reset mid-left word (reset_n low for 3 clk cycles at bit 12): outputs zero immediately. The next complete frame (L = 24'h800000, R = 24'h7FFFFF) yields the correct pair.
- Back-to-back frames: 4 consecutive frames with incrementing values. Required: 4 strobes spaced 64 BCLKs apart, each appearing SYNC_STAGES+2 clk cycles after the final right bit's BCLK high, with values in order.
